// File: rtl/arilla_arbiter_pkg.sv
// rtl/arilla_arbiter_pkg.sv - shared types for the two-requester arilla bus arbiter
package arilla_arbiter_pkg;

   typedef enum logic {
      OWNER_HART  = 1'b0,
      OWNER_DEBUG = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   is_read;
      logic   miss;
   } resp_t;

   typedef enum logic [1:0] {
      LOCK_OPEN  = 2'd0,
      LOCK_HART  = 2'd1,
      LOCK_DEBUG = 2'd2
   } lock_state_e;

   function automatic owner_e other_owner(input owner_e o);
      return (o == OWNER_HART) ? OWNER_DEBUG : OWNER_HART;
   endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// rtl/arilla_bus_if.sv - arilla bus segment shared by a manager and its RAM devices
interface arilla_bus_if #(
   parameter int AddressWidth = 16,
   parameter int DataWidth    = 32,
   parameter int BytesPerWord = DataWidth / 8
);
   logic [AddressWidth-1:0] address;
   logic [BytesPerWord-1:0] byte_enable;
   logic [DataWidth-1:0]    data_ctp;
   logic [DataWidth-1:0]    data_ptc;
   logic                    read;
   logic                    write;
   logic                    hit;
   logic                    intercept;

   // The manager never drives intercept, so it is left out of its view.
   modport master (
      output address, byte_enable, data_ctp, read, write,
      input  hit, data_ptc
   );

   modport slave (
      input  address, byte_enable, data_ctp, read, write,
      output hit, data_ptc, intercept
   );
endinterface

// File: rtl/arilla_arbiter_pick.sv
// rtl/arilla_arbiter_pick.sv - combinational 2-way pick honouring lock owner and priority
module arilla_arbiter_pick
   import arilla_arbiter_pkg::*;
(
   input  logic [1:0]  req_i,
   input  owner_e      prio_i,
   input  lock_state_e lock_state_i,
   output logic [1:0]  grant_o
);

   always_comb begin
      grant_o = 2'b00;
      case (lock_state_i)
         LOCK_HART:  grant_o[0] = req_i[0];
         LOCK_DEBUG: grant_o[1] = req_i[1];
         default: begin
            if (req_i == 2'b11) begin
               grant_o = (prio_i == OWNER_HART) ? 2'b01 : 2'b10;
            end else begin
               grant_o = req_i;
            end
         end
      endcase
   end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// rtl/arilla_bus_arbiter.sv - hart/debug arbiter for one arilla bus segment
// ARILLA_ARBITER_ROUND_ROBIN_EN selects round-robin; otherwise debug has fixed priority.
module arilla_bus_arbiter
   import arilla_arbiter_pkg::*;
#(
   parameter int NumRequesters = 2,
   parameter int AddressWidth  = 16,
   parameter int DataWidth     = 32,
   parameter int BytesPerWord  = DataWidth / 8
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    r0_read,
   input  logic                    r0_write,
   input  logic                    r0_lock,
   input  logic [AddressWidth-1:0] r0_address,
   input  logic [BytesPerWord-1:0] r0_byte_enable,
   input  logic [DataWidth-1:0]    r0_wdata,
   output logic                    r0_ready,
   output logic                    r0_resp_valid,
   output logic                    r0_resp_err,
   output logic [DataWidth-1:0]    r0_rdata,

   input  logic                    r1_read,
   input  logic                    r1_write,
   input  logic                    r1_lock,
   input  logic [AddressWidth-1:0] r1_address,
   input  logic [BytesPerWord-1:0] r1_byte_enable,
   input  logic [DataWidth-1:0]    r1_wdata,
   output logic                    r1_ready,
   output logic                    r1_resp_valid,
   output logic                    r1_resp_err,
   output logic [DataWidth-1:0]    r1_rdata,

   arilla_bus_if.master            bus_interface
);

   if (NumRequesters != 2) begin : gen_bad_requester_count
      $error("arilla_bus_arbiter supports exactly two requesters");
   end

   logic [1:0]  req;
   logic [1:0]  grant;
   owner_e      prio;
   lock_state_e lock_q;
   resp_t       resp_q;
   resp_t       resp_d;

   // Nothing is accepted while reset is held.
   assign req = {r1_read | r1_write, r0_read | r0_write} & {2{~rst}};

`ifdef ARILLA_ARBITER_ROUND_ROBIN_EN
   owner_e rr_q;
   owner_e rr_d;

   always_comb begin
      rr_d = rr_q;
      if (grant[0]) begin
         rr_d = other_owner(OWNER_HART);
      end else if (grant[1]) begin
         rr_d = other_owner(OWNER_DEBUG);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= OWNER_HART;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign prio = rr_q;
`else
   assign prio = OWNER_DEBUG;
`endif

   arilla_arbiter_pick u_pick (
      .req_i        (req),
      .prio_i       (prio),
      .lock_state_i (lock_q),
      .grant_o      (grant)
   );

   assign r0_ready = grant[0];
   assign r1_ready = grant[1];

   always_comb begin
      bus_interface.read        = 1'b0;
      bus_interface.write       = 1'b0;
      bus_interface.address     = '0;
      bus_interface.byte_enable = '0;
      bus_interface.data_ctp    = '0;
      if (grant[0]) begin
         bus_interface.read        = r0_read;
         bus_interface.write       = r0_write;
         bus_interface.address     = r0_address;
         bus_interface.byte_enable = r0_byte_enable;
         bus_interface.data_ctp    = r0_wdata;
      end else if (grant[1]) begin
         bus_interface.read        = r1_read;
         bus_interface.write       = r1_write;
         bus_interface.address     = r1_address;
         bus_interface.byte_enable = r1_byte_enable;
         bus_interface.data_ctp    = r1_wdata;
      end
   end

   // The lock follows the owner's lock bit every cycle, so an idle owner can release it.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= LOCK_OPEN;
      end else begin
         case (lock_q)
            LOCK_OPEN: begin
               if (grant[0] && r0_lock) begin
                  lock_q <= LOCK_HART;
               end else if (grant[1] && r1_lock) begin
                  lock_q <= LOCK_DEBUG;
               end
            end
            LOCK_HART: begin
               if (!r0_lock) begin
                  lock_q <= LOCK_OPEN;
               end
            end
            LOCK_DEBUG: begin
               if (!r1_lock) begin
                  lock_q <= LOCK_OPEN;
               end
            end
            default: lock_q <= LOCK_OPEN;
         endcase
      end
   end

   // A floating hit line must read as a miss, hence the case-inequality.
   always_comb begin
      resp_d = '0;
      if (|grant) begin
         resp_d.valid   = 1'b1;
         resp_d.owner   = grant[1] ? OWNER_DEBUG : OWNER_HART;
         resp_d.is_read = grant[1] ? r1_read : r0_read;
         resp_d.miss    = (bus_interface.hit !== 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_q <= '0;
      end else begin
         resp_q <= resp_d;
      end
   end

   logic                 resp_live;
   logic [DataWidth-1:0] resp_data;
   logic                 to_hart;
   logic                 to_debug;

   // Reset also drops a response that was due in the reset cycle.
   assign resp_live = resp_q.valid & ~rst;
   assign resp_data = (resp_q.is_read && !resp_q.miss) ? bus_interface.data_ptc : '0;
   assign to_hart   = resp_live && (resp_q.owner == OWNER_HART);
   assign to_debug  = resp_live && (resp_q.owner == OWNER_DEBUG);

   assign r0_resp_valid = to_hart;
   assign r0_resp_err   = to_hart & resp_q.miss;
   assign r0_rdata      = to_hart ? resp_data : '0;

   assign r1_resp_valid = to_debug;
   assign r1_resp_err   = to_debug & resp_q.miss;
   assign r1_rdata      = to_debug ? resp_data : '0;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb/tb_arilla_bus_arbiter.sv - scoreboard bench for arilla_bus_arbiter with a 64-word RAM device
module tb_arilla_bus_arbiter;
   import arilla_arbiter_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int BW = 4;
`ifdef ARILLA_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          r0_read, r0_write, r0_lock, r0_ready, r0_resp_valid, r0_resp_err;
   logic [AW-1:0] r0_address;
   logic [BW-1:0] r0_byte_enable;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic          r1_read, r1_write, r1_lock, r1_ready, r1_resp_valid, r1_resp_err;
   logic [AW-1:0] r1_address;
   logic [BW-1:0] r1_byte_enable;
   logic [DW-1:0] r1_wdata, r1_rdata;

   arilla_bus_if #(.AddressWidth(AW), .DataWidth(DW), .BytesPerWord(BW)) bus ();

   arilla_bus_arbiter #(.NumRequesters(2), .AddressWidth(AW), .DataWidth(DW), .BytesPerWord(BW)) dut (
      .clk(clk), .rst(rst),
      .r0_read(r0_read), .r0_write(r0_write), .r0_lock(r0_lock), .r0_address(r0_address),
      .r0_byte_enable(r0_byte_enable), .r0_wdata(r0_wdata), .r0_ready(r0_ready),
      .r0_resp_valid(r0_resp_valid), .r0_resp_err(r0_resp_err), .r0_rdata(r0_rdata),
      .r1_read(r1_read), .r1_write(r1_write), .r1_lock(r1_lock), .r1_address(r1_address),
      .r1_byte_enable(r1_byte_enable), .r1_wdata(r1_wdata), .r1_ready(r1_ready),
      .r1_resp_valid(r1_resp_valid), .r1_resp_err(r1_resp_err), .r1_rdata(r1_rdata),
      .bus_interface(bus)
   );

   // RAM device on words 0x00-0x3F, one-cycle read latency
   logic [DW-1:0] mem [64];
   logic [DW-1:0] dev_rdata_q;
   assign bus.hit       = (bus.read | bus.write) && (bus.address < 16'd64);
   assign bus.intercept = 1'b0;
   assign bus.data_ptc  = dev_rdata_q;

   always @(posedge clk) begin
      dev_rdata_q <= '0;
      if (rst) begin
         mem[6'h20] <= 32'hAAAA0000;
         mem[6'h21] <= 32'h5555FFFF;
         mem[6'h30] <= 32'h11223344;
      end else begin
         if (bus.hit && bus.read) dev_rdata_q <= mem[bus.address[5:0]];
         if (bus.hit && bus.write) begin
            for (int b = 0; b < BW; b++) begin
               if (bus.byte_enable[b]) mem[bus.address[5:0]][8*b +: 8] <= bus.data_ctp[8*b +: 8];
            end
         end
      end
   end

   typedef struct {
      logic          rd, wr, lk;
      logic [AW-1:0] a;
      logic [BW-1:0] be;
      logic [DW-1:0] wd;
      logic          rdy, rsp, err;
      logic [DW-1:0] rdat;
   } req_t;

   typedef struct {
      int            due;
      logic          err;
      logic [DW-1:0] rdat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic req_t req_idle(input logic lk);
      req_t r;
      r = '{default: '0};
      r.lk = lk;
      return r;
   endfunction

   function automatic req_t req_rd(input logic [AW-1:0] a, input logic lk, input logic rdy,
                                   input logic [DW-1:0] d, input logic e);
      req_t r;
      r = req_idle(lk);
      r.rd = 1'b1; r.a = a; r.rdy = rdy; r.rsp = rdy; r.rdat = d; r.err = e;
      return r;
   endfunction

   function automatic req_t req_wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] wd,
                                   input logic lk, input logic rdy, input logic e);
      req_t r;
      r = req_idle(lk);
      r.wr = 1'b1; r.a = a; r.be = be; r.wd = wd; r.rdy = rdy; r.rsp = rdy; r.err = e;
      return r;
   endfunction

   task automatic step(input req_t a, input req_t b, input logic rs, input string tag);
      exp_t x;
      @(negedge clk);
      rst = rs;
      r0_read = a.rd; r0_write = a.wr; r0_lock = a.lk; r0_address = a.a;
      r0_byte_enable = a.be; r0_wdata = a.wd;
      r1_read = b.rd; r1_write = b.wr; r1_lock = b.lk; r1_address = b.a;
      r1_byte_enable = b.be; r1_wdata = b.wd;
      #1;
      check({tag, " r0_ready"}, 64'(r0_ready), 64'(a.rdy));
      check({tag, " r1_ready"}, 64'(r1_ready), 64'(b.rdy));
      if (!a.rdy && !b.rdy) begin
         check({tag, " bus_idle"},
               {10'd0, bus.read, bus.write, bus.address, bus.byte_enable, bus.data_ctp}, 64'd0);
      end
      if (a.rsp) begin
         x = '{due: cyc + 1, err: a.err, rdat: a.rdat};
         q0.push_back(x);
      end
      if (b.rsp) begin
         x = '{due: cyc + 1, err: b.err, rdat: b.rdat};
         q1.push_back(x);
      end
   endtask

   task automatic mon(input int i, input logic v, input logic e, input logic [DW-1:0] d);
      exp_t x;
      int   sz;
      sz = (i == 0) ? q0.size() : q1.size();
      if (v) begin
         if (sz == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL r%0d unexpected_resp at cycle %0d: got resp_valid=1 want 0", i, cyc);
         end else begin
            x = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("r%0d resp_cycle", i), 64'(cyc), 64'(x.due));
            check($sformatf("r%0d resp_err", i), 64'(e), 64'(x.err));
            check($sformatf("r%0d rdata", i), 64'(d), 64'(x.rdat));
         end
      end else if (sz != 0) begin
         x = (i == 0) ? q0[0] : q1[0];
         if (x.due <= cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL r%0d missing_resp at cycle %0d: got resp_valid=0 want 1", i, cyc);
            if (i == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         mon(0, r0_resp_valid, r0_resp_err, r0_rdata);
         mon(1, r1_resp_valid, r1_resp_err, r1_rdata);
      end
   end

   initial begin : stimulus
      req_t r;
      rst = 1'b1;
      r0_read = 0; r0_write = 0; r0_lock = 0; r0_address = '0; r0_byte_enable = '0; r0_wdata = '0;
      r1_read = 0; r1_write = 0; r1_lock = 0; r1_address = '0; r1_byte_enable = '0; r1_wdata = '0;

      step(req_idle(0), req_idle(0), 1'b1, "reset");
      step(req_rd(16'h10, 0, 0, 0, 0), req_idle(0), 1'b1, "reset_req");

      step(req_wr(16'h10, 4'hF, 32'hDEADBEEF, 0, 1, 0), req_idle(0), 1'b0, "t1_write");
      step(req_rd(16'h10, 0, 1, 32'hDEADBEEF, 0), req_idle(0), 1'b0, "t1_read");

      // r1 alone first so the round-robin pointer favours r0 at the contention start
      step(req_idle(0), req_rd(16'h21, 0, 1, 32'h5555FFFF, 0), 1'b0, "t2_prime");
      for (int k = 0; k < 4; k++) begin
         step(req_rd(16'h20, 0, RR ? (k % 2 == 0) : 1'b0, 32'hAAAA0000, 0),
              req_rd(16'h21, 0, RR ? (k % 2 == 1) : 1'b1, 32'h5555FFFF, 0),
              1'b0, $sformatf("t2_contend%0d", k));
      end
      step(req_rd(16'h20, 0, 1, 32'hAAAA0000, 0), req_idle(0), 1'b0, "t2_drain");

      step(req_rd(16'h20, 1, 1, 32'hAAAA0000, 0), req_idle(0), 1'b0, "t3_lock0");
      step(req_rd(16'h10, 1, 1, 32'hDEADBEEF, 0), req_rd(16'h21, 0, 0, 0, 0), 1'b0, "t3_lock1");
      step(req_rd(16'h20, 1, 1, 32'hAAAA0000, 0), req_rd(16'h21, 0, 0, 0, 0), 1'b0, "t3_lock2");
      step(req_wr(16'h12, 4'hF, 32'h01234567, 0, 1, 0), req_rd(16'h21, 0, 0, 0, 0), 1'b0, "t3_unlock");
      step(req_idle(0), req_rd(16'h21, 0, 1, 32'h5555FFFF, 0), 1'b0, "t3_handover");
      step(req_rd(16'h12, 1, 1, 32'h01234567, 0), req_idle(0), 1'b0, "t3_relock");
      step(req_idle(1), req_rd(16'h21, 0, 0, 0, 0), 1'b0, "t3_idle_hold");
      step(req_idle(0), req_rd(16'h21, 0, 0, 0, 0), 1'b0, "t3_idle_release");
      step(req_idle(0), req_rd(16'h21, 0, 1, 32'h5555FFFF, 0), 1'b0, "t3_after_release");

      step(req_rd(16'h100, 0, 1, 32'h0, 1), req_idle(0), 1'b0, "t4_rd_miss");
      step(req_idle(0), req_wr(16'h200, 4'hF, 32'hFFFFFFFF, 0, 1, 1), 1'b0, "t4_wr_miss");

      step(req_wr(16'h30, 4'b0010, 32'h0000AB00, 0, 1, 0), req_idle(0), 1'b0, "t5_merge_wr");
      step(req_rd(16'h30, 0, 1, 32'h1122AB44, 0), req_idle(0), 1'b0, "t5_merge_rd");

      // The response to this accept falls in the reset cycle and must vanish.
      r = req_rd(16'h20, 0, 1, 32'hAAAA0000, 0);
      r.rsp = 1'b0;
      step(r, req_idle(0), 1'b0, "t6_accept");
      step(req_rd(16'h20, 0, 0, 0, 0), req_rd(16'h21, 0, 0, 0, 0), 1'b1, "t6_reset");
      step(req_rd(16'h20, 0, RR, 32'hAAAA0000, 0), req_rd(16'h21, 0, !RR, 32'h5555FFFF, 0),
           1'b0, "t6_contend");
      step(RR ? req_idle(0) : req_rd(16'h20, 0, 1, 32'hAAAA0000, 0),
           RR ? req_rd(16'h21, 0, 1, 32'h5555FFFF, 0) : req_idle(0), 1'b0, "t6_second");

      for (int k = 0; k < 3; k++) step(req_idle(0), req_idle(0), 1'b0, "drain");
      #3;
      check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
